nano_dbus_bridge: RTL and testbench
===================================

NANO_DBUS_BRIDGE -- requirements
Module: nano_dbus_bridge

Interface
REQ-001 Parameter: TIMEOUT, default 16 (legal 1..255), the number of cycles in REQ without m_ack_i before the transfer is aborted.
REQ-002 Port: clk_i  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_i  in  1  reset; asynchronous, active-high.
REQ-004 Port: d_addr_i  in  32  core data address.
REQ-005 Port: d_wdata_i  in  32  core store data.
REQ-006 Port: d_rd_i  in  4  core load byte-lane enables.
REQ-007 Port: d_we_i  in  4  core store byte-lane enables.
REQ-008 Port: d_rdata_o  out  32  load data returned to the core.
REQ-009 Port: stall_o  out  1  freezes the core while a transfer is pending.
REQ-010 Port: err_o  out  1  one-cycle pulse on a timeout abort.
REQ-011 Port: m_req_o  out  1  memory request, level; held until acknowledged or aborted.
REQ-012 Port: m_we_o  out  1  1 = write, 0 = read.
REQ-013 Port: m_addr_o  out  32  word-aligned address.
REQ-014 Port: m_be_o  out  4  byte enables.
REQ-015 Port: m_wdata_o  out  32  write data.
REQ-016 Port: m_ack_i  in  1  memory acknowledge, single-cycle pulse.
REQ-017 Port: m_rdata_i  in  32  read data, valid only in the cycle m_ack_i=1.

Function
REQ-018 The FSM SHALL have three states: IDLE, REQ and DONE.
REQ-019 A core request SHALL be defined as (d_rd_i != 0) or (d_we_i != 0).
REQ-020 In IDLE with a core request present, stall_o SHALL be 1 combinationally and the next state SHALL be REQ.
REQ-021 On that IDLE-to-REQ edge, the block SHALL latch: m_addr_o = {d_addr_i[31:2], 2'b00}, m_wdata_o = d_wdata_i, m_we_o = |d_we_i, and m_be_o = d_we_i if |d_we_i, else d_rd_i.
REQ-022 If d_rd_i and d_we_i are both nonzero, the write SHALL take priority and the read enables SHALL be ignored.
REQ-023 In REQ, m_req_o and stall_o SHALL be 1, and all latched m_* fields SHALL be held stable.
REQ-024 In REQ with m_ack_i=1, the next state SHALL be DONE, and for a read the rdata register SHALL capture m_rdata_i with disabled byte lanes forced to 0x00.
REQ-025 A write SHALL leave the rdata register unchanged.
REQ-026 In DONE, stall_o SHALL be 0, m_req_o SHALL be 0, d_rdata_o SHALL equal the rdata register, and the next state SHALL be IDLE unconditionally.
REQ-027 The core request present during DONE SHALL be treated as complete and SHALL NOT be reissued.
REQ-028 A timeout counter SHALL clear on entry to REQ and increment each REQ cycle without ack.
REQ-029 When the counter reaches TIMEOUT-1 with no ack, the block SHALL go to DONE, set the rdata register to 32'h0000_0000, and pulse err_o in the DONE cycle.
REQ-030 An ack arriving in the same cycle as the timeout SHALL win; no error is raised.
REQ-031 m_ack_i arriving in IDLE or DONE SHALL be ignored.
REQ-032 Minimum latency: request in cycle 0, m_req_o=1 in cycle 1, ack in cycle 1, DONE (stall_o=0) in cycle 2; each extra wait cycle adds one stall cycle.
REQ-033 d_rdata_o SHALL hold its value outside DONE.

Reset
REQ-034 While rst_i=1, the block SHALL be forced asynchronously to: state IDLE, m_req_o=0, m_we_o=0, m_be_o=0, m_addr_o=0, m_wdata_o=0, rdata=0, d_rdata_o=0, err_o=0, counter=0.
REQ-035 While rst_i=1, stall_o SHALL be 0.
REQ-036 A reset asserted mid-transfer SHALL drop m_req_o immediately.
REQ-037 A late m_ack_i arriving after reset SHALL be ignored.
REQ-038 After reset deassertion, the first transfer SHALL start only from a fresh core request sampled in IDLE.

Verification
REQ-039 Read, zero-wait: d_rd_i=4'hF, addr 0x0000_0006, ack in cycle 1 with m_rdata_i=0x1234_5678 -> m_addr_o=0x0000_0004, m_be_o=F, stall_o 1 for 2 cycles, d_rdata_o=0x1234_5678 in cycle 2.
REQ-040 Byte write with waits: d_we_i=4'b0100, wdata 0x00AB_0000, ack after 3 wait cycles -> m_we_o=1, m_be_o=0100, stall_o high for 5 cycles, err_o stays 0.
REQ-041 Partial read: d_rd_i=4'b0011, m_rdata_i=0xDEAD_BEEF -> d_rdata_o=0x0000_BEEF.
REQ-042 Timeout, TIMEOUT=4, no ack: m_req_o high 4 cycles, then DONE with err_o=1 for one cycle and d_rdata_o=0; a later ack is ignored.
REQ-043 Simultaneous rd/we: d_rd_i=F, d_we_i=F -> write issued (m_we_o=1, m_be_o=F).
REQ-044 Reset in REQ: rst_i raised mid-wait -> m_req_o and stall_o go to 0 without a clock edge; an ack one cycle later produces no DONE.

Source files
------------

// File: rtl/nano_dbus_bridge.sv
// nano_dbus_bridge: turns a core's load/store byte-lane strobes into a single
// level-held memory request, freezing the core until the memory acknowledges
// or a bounded wait expires.
module nano_dbus_bridge #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [3:0]  d_rd_i,
    input  logic [3:0]  d_we_i,
    output logic [31:0] d_rdata_o,
    output logic        stall_o,
    output logic        err_o,
    output logic        m_req_o,
    output logic        m_we_o,
    output logic [31:0] m_addr_o,
    output logic [3:0]  m_be_o,
    output logic [31:0] m_wdata_o,
    input  logic        m_ack_i,
    input  logic [31:0] m_rdata_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Last wait count before the transfer is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q,   state_d;
    logic        m_we_q,    m_we_d;
    logic [3:0]  m_be_q,    m_be_d;
    logic [31:0] m_addr_q,  m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [31:0] rdata_q,   rdata_d;
    logic        err_q,     err_d;
    logic [7:0]  cnt_q,     cnt_d;

    logic        core_req;
    logic        is_write;

    // The address is always issued word-aligned, so the low bits are dropped.
    logic        unused_addr_lsbs;
    assign unused_addr_lsbs = ^d_addr_i[1:0];

    assign core_req = (d_rd_i != 4'h0) || (d_we_i != 4'h0);
    assign is_write = (d_we_i != 4'h0);

    // Next-state logic: latch the request on issue, wait for ack or timeout.
    always_comb begin
        state_d   = state_q;
        m_we_d    = m_we_q;
        m_be_d    = m_be_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        rdata_d   = rdata_q;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (core_req) begin
                    state_d   = ST_REQ;
                    m_addr_d  = {d_addr_i[31:2], 2'b00};
                    m_wdata_d = d_wdata_i;
                    m_we_d    = is_write;
                    m_be_d    = is_write ? d_we_i : d_rd_i;
                    cnt_d     = 8'h00;
                end
            end
            ST_REQ: begin
                if (m_ack_i) begin
                    state_d = ST_DONE;
                    if (!m_we_q) begin
                        for (int i = 0; i < 4; i++) begin
                            rdata_d[8*i +: 8] = m_be_q[i] ? m_rdata_i[8*i +: 8] : 8'h00;
                        end
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    rdata_d = 32'h0000_0000;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'h01;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched transfer registers, cleared asynchronously on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            m_we_q    <= 1'b0;
            m_be_q    <= 4'h0;
            m_addr_q  <= 32'h0;
            m_wdata_q <= 32'h0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
            cnt_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            m_we_q    <= m_we_d;
            m_be_q    <= m_be_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    // Stall is combinational so the core freezes in the same cycle it asks.
    assign stall_o   = !rst_i && (((state_q == ST_IDLE) && core_req) || (state_q == ST_REQ));
    assign m_req_o   = (state_q == ST_REQ);
    assign m_we_o    = m_we_q;
    assign m_be_o    = m_be_q;
    assign m_addr_o  = m_addr_q;
    assign m_wdata_o = m_wdata_q;
    assign d_rdata_o = rdata_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_nano_dbus_bridge.sv
// Scoreboard bench for nano_dbus_bridge: stimulus pushes expected issue and
// completion records, a monitor pops and compares when the DUT presents them.
module tb_nano_dbus_bridge;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
    logic [3:0]  d_rd_i, d_we_i;
    logic        stall_o, err_o, m_req_o, m_we_o, m_ack_i;
    logic [31:0] m_addr_o, m_wdata_o, m_rdata_i;
    logic [3:0]  m_be_o;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } issue_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } done_t;

    issue_t issue_q[$];
    done_t  done_q[$];

    nano_dbus_bridge #(.TIMEOUT(TO)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .d_addr_i  (d_addr_i),
        .d_wdata_i (d_wdata_i),
        .d_rd_i    (d_rd_i),
        .d_we_i    (d_we_i),
        .d_rdata_o (d_rdata_o),
        .stall_o   (stall_o),
        .err_o     (err_o),
        .m_req_o   (m_req_o),
        .m_we_o    (m_we_o),
        .m_addr_o  (m_addr_o),
        .m_be_o    (m_be_o),
        .m_wdata_o (m_wdata_o),
        .m_ack_i   (m_ack_i),
        .m_rdata_i (m_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a rising m_req_o is an issue, a falling one outside reset is a DONE cycle.
    logic prev_req = 1'b0;
    always @(negedge clk_i) begin
        if (!prev_req && m_req_o) begin
            if (issue_q.size() == 0) begin
                check("unexpected_issue", 32'd1, 32'd0);
            end else begin
                issue_t e;
                e = issue_q.pop_front();
                check("m_we_o", {31'd0, m_we_o}, {31'd0, e.we});
                check("m_be_o", {28'd0, m_be_o}, {28'd0, e.be});
                check("m_addr_o", m_addr_o, e.addr);
                check("m_wdata_o", m_wdata_o, e.wdata);
            end
        end else if (prev_req && !m_req_o && !rst_i) begin
            if (done_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                done_t d;
                d = done_q.pop_front();
                check("d_rdata_o", d_rdata_o, d.rdata);
                check("err_o_done", {31'd0, err_o}, {31'd0, d.err});
                check("stall_o_done", {31'd0, stall_o}, 32'd0);
            end
        end else if (err_o) begin
            check("err_o_spurious", {31'd0, err_o}, 32'd0);
        end
        prev_req <= rst_i ? 1'b0 : m_req_o;
    end

    // One core transfer; ack after `waits` REQ cycles, or never when do_ack is 0.
    task automatic run_txn(input logic [3:0] rd, input logic [3:0] we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int waits, input logic do_ack,
                           input logic [31:0] rdata, input issue_t exp_issue,
                           input done_t exp_done, input int exp_stall, input string name);
        int stall_cnt = 0;
        bit finished = 0;
        issue_q.push_back(exp_issue);
        done_q.push_back(exp_done);
        @(posedge clk_i); #1;
        d_rd_i = rd; d_we_i = we; d_addr_i = addr; d_wdata_i = wdata;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk_i);
            if (!stall_o) begin
                finished = 1;
                break;
            end
            stall_cnt++;
            @(posedge clk_i); #1;
            m_ack_i   = do_ack && (cyc == waits);
            m_rdata_i = rdata;
        end
        if (!finished) check({name, "_bound"}, 32'd0, 32'd1);
        check({name, "_stall_cycles"}, stall_cnt, exp_stall);
        @(posedge clk_i); #1;
        d_rd_i = 4'h0; d_we_i = 4'h0; m_ack_i = 1'b0;
        @(negedge clk_i);
        check({name, "_no_reissue"}, {31'd0, m_req_o}, 32'd0);
    endtask

    initial begin
        rst_i = 1'b1;
        d_rd_i = 4'hF; d_we_i = 4'h0; d_addr_i = 32'h0000_0008; d_wdata_i = 32'h0;
        m_ack_i = 1'b0; m_rdata_i = 32'h0;
        #12;
        check("rst_stall_o", {31'd0, stall_o}, 32'd0);
        check("rst_m_req_o", {31'd0, m_req_o}, 32'd0);
        check("rst_d_rdata_o", d_rdata_o, 32'd0);
        check("rst_m_addr_o", m_addr_o, 32'd0);
        check("rst_err_o", {31'd0, err_o}, 32'd0);
        d_rd_i = 4'h0;
        @(negedge clk_i);
        rst_i = 1'b0;

        run_txn(4'hF, 4'h0, 32'h0000_0006, 32'h5555_AAAA, 0, 1'b1, 32'h1234_5678,
                '{we: 1'b0, be: 4'hF, addr: 32'h0000_0004, wdata: 32'h5555_AAAA},
                '{rdata: 32'h1234_5678, err: 1'b0}, 2, "read_zero_wait");
        run_txn(4'h0, 4'b0100, 32'h1000_0013, 32'h00AB_0000, 3, 1'b1, 32'hFFFF_FFFF,
                '{we: 1'b1, be: 4'b0100, addr: 32'h1000_0010, wdata: 32'h00AB_0000},
                '{rdata: 32'h1234_5678, err: 1'b0}, 5, "byte_write_ack_at_limit");
        run_txn(4'b0011, 4'h0, 32'h0000_0020, 32'h0, 1, 1'b1, 32'hDEAD_BEEF,
                '{we: 1'b0, be: 4'b0011, addr: 32'h0000_0020, wdata: 32'h0},
                '{rdata: 32'h0000_BEEF, err: 1'b0}, 3, "partial_read");
        run_txn(4'hF, 4'h0, 32'h0000_0044, 32'h0, 0, 1'b0, 32'h0,
                '{we: 1'b0, be: 4'hF, addr: 32'h0000_0044, wdata: 32'h0},
                '{rdata: 32'h0, err: 1'b1}, 5, "timeout");

        // Late ack with nothing outstanding must be ignored.
        @(posedge clk_i); #1;
        m_ack_i = 1'b1; m_rdata_i = 32'h7777_7777;
        @(negedge clk_i);
        check("late_ack_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk_i); #1;
        m_ack_i = 1'b0;
        @(negedge clk_i);
        check("late_ack_rdata", d_rdata_o, 32'd0);

        run_txn(4'hF, 4'hF, 32'h0000_0101, 32'hCAFE_F00D, 0, 1'b1, 32'h9999_9999,
                '{we: 1'b1, be: 4'hF, addr: 32'h0000_0100, wdata: 32'hCAFE_F00D},
                '{rdata: 32'h0, err: 1'b0}, 2, "rd_we_priority");
        run_txn(4'b1000, 4'h0, 32'h0000_0200, 32'h0, 2, 1'b1, 32'hA1B2_C3D4,
                '{we: 1'b0, be: 4'b1000, addr: 32'h0000_0200, wdata: 32'h0},
                '{rdata: 32'hA100_0000, err: 1'b0}, 4, "top_byte_read");

        // Reset raised while waiting in REQ drops the request without a clock edge.
        issue_q.push_back('{we: 1'b0, be: 4'hF, addr: 32'h0000_0300, wdata: 32'h0});
        @(posedge clk_i); #1;
        d_rd_i = 4'hF; d_addr_i = 32'h0000_0300;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("pre_reset_req", {31'd0, m_req_o}, 32'd1);
        #2;
        rst_i = 1'b1; d_rd_i = 4'h0;
        #1;
        check("reset_drops_req", {31'd0, m_req_o}, 32'd0);
        check("reset_drops_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk_i); #2;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        m_ack_i = 1'b1; m_rdata_i = 32'h5A5A_5A5A;
        @(negedge clk_i);
        check("post_reset_ack_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk_i); #1;
        m_ack_i = 1'b0;
        @(negedge clk_i);
        check("post_reset_ack_req", {31'd0, m_req_o}, 32'd0);
        check("post_reset_ack_rdata", d_rdata_o, 32'd0);

        run_txn(4'b0100, 4'h0, 32'h0000_0400, 32'h0, 0, 1'b1, 32'h1122_3344,
                '{we: 1'b0, be: 4'b0100, addr: 32'h0000_0400, wdata: 32'h0},
                '{rdata: 32'h0022_0000, err: 1'b0}, 2, "read_after_reset");

        repeat (2) @(posedge clk_i);
        check("issue_queue_drained", issue_q.size(), 32'd0);
        check("done_queue_drained", done_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
